// File: rtl/gpu_mem_arbiter_pkg.sv
// Shared types for the voxel_gpu m1 memory arbiter: client ids, command record, FSM states.
package gpu_mem_arbiter_pkg;

    parameter int MEM_CLIENTS = 4;

    typedef enum logic [1:0] {
        MC_VOXEL,
        MC_PALETTE,
        MC_PIXEL,
        MC_SPARE
    } mem_client_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/gpu_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting client after i_ptr, wrapping modulo N.
module gpu_rr_pick
    import gpu_mem_arbiter_pkg::*;
#(
    parameter int N  = MEM_CLIENTS,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Walk the offsets from farthest to nearest so the nearest requester wins the last overwrite.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_idx = PW'((int'(i_ptr) + k) % N);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide Avalon-MM master m1 among NUM_REQ clients,
// one transaction in flight, with a watchdog that aborts transfers that never complete.
module gpu_mem_arbiter
    import gpu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = MEM_CLIENTS,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_error,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m1_address,
    output logic                      m1_read,
    output logic                      m1_write,
    output logic [DATA_W-1:0]         m1_writedata,
    input  logic                      m1_waitrequest,
    input  logic [DATA_W-1:0]         m1_readdata,
    input  logic                      m1_readdatavalid,
    output logic [1:0]                dbg_state
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_CMD  = ARB_CMD;
    localparam logic [1:0] S_RESP = ARB_RESP;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [TW-1:0]      r_timer;
    logic               r_m1_read;
    logic               r_m1_write;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_error;

    logic [PW-1:0]      w_pick;
    logic               w_any;
    logic               w_finish;
    logic               w_to_resp;
    logic               w_abort;
    logic               w_expire;
    logic [DATA_W-1:0]  w_fin_data;

    gpu_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // r_ptr doubles as the index of the client owning the transaction in flight.
    assign w_expire = (TIMEOUT != 0) && (r_timer == TLAST);

    always_comb begin
        w_finish   = 1'b0;
        w_to_resp  = 1'b0;
        w_fin_data = '0;
        case (r_state)
            S_CMD: begin
                if (!m1_waitrequest) begin
                    if (r_write) begin
                        w_finish = 1'b1;
                    end else if (m1_readdatavalid) begin
                        w_finish   = 1'b1;
                        w_fin_data = m1_readdata;
                    end else begin
                        w_to_resp = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (m1_readdatavalid) begin
                    w_finish   = 1'b1;
                    w_fin_data = m1_readdata;
                end
            end
            default: ;
        endcase
        w_abort = (r_state != S_IDLE) && !w_finish && w_expire;
    end

    always_comb begin
        req_ready = '0;
        if (reset_n && (r_state == S_IDLE) && w_any) begin
            req_ready[w_pick] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= PW'(NUM_REQ - 1);
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_timer     <= '0;
            r_m1_read   <= 1'b0;
            r_m1_write  <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_ptr      <= w_pick;
                    r_write    <= req_write[w_pick];
                    r_addr     <= req_addr[w_pick*ADDR_W +: ADDR_W];
                    r_wdata    <= req_wdata[w_pick*DATA_W +: DATA_W];
                    r_timer    <= '0;
                    r_m1_read  <= !req_write[w_pick];
                    r_m1_write <= req_write[w_pick];
                    r_state    <= S_CMD;
                end
            end else if (w_finish || w_abort) begin
                // A real completion beats a watchdog expiry landing on the same cycle.
                r_state     <= S_IDLE;
                r_m1_read   <= 1'b0;
                r_m1_write  <= 1'b0;
                r_rsp_valid <= NUM_REQ'(1) << r_ptr;
                r_rsp_data  <= w_fin_data;
                r_rsp_error <= w_abort;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (w_to_resp) begin
                    r_m1_read <= 1'b0;
                    r_state   <= S_RESP;
                end
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_error    = r_rsp_error;
    assign busy         = (r_state != S_IDLE);
    assign m1_address   = r_addr;
    assign m1_read      = r_m1_read;
    assign m1_write     = r_m1_write;
    assign m1_writedata = r_wdata;
    assign dbg_state    = r_state;

endmodule
